id_stage: RTL



---
 rtl/id_stage.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// id_stage: registered RV32 decode stage between fetch and execute.
// Accepts one instruction per cycle over valid/ready, emits a registered
// decoded bundle (fields, sign-extended immediate, class flags, illegal).
// Optional feature macro: ID_STAGE_SKID_EN adds a one-entry skid buffer so
// that in_ready comes straight from a register.
module id_stage #(
  parameter int unsigned XLEN              = 32,
  parameter int unsigned PC_WIDTH          = 32,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [6:0]                   opcode,
  output logic [4:0]                   rd,
  output logic [4:0]                   rs1,
  output logic [4:0]                   rs2,
  output logic [2:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [XLEN-1:0]              imm,
  output logic [2:0]                   instr_type,
  output logic                         alu_reg_reg_op,
  output logic                         alu_reg_con_op,
  output logic                         alu_branch_op,
  output logic                         load_op,
  output logic                         store_op,
  output logic                         jump_op,
  output logic                         illegal
);

  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_S   = 3'd2;
  localparam logic [2:0] TYPE_B   = 3'd3;
  localparam logic [2:0] TYPE_U   = 3'd4;
  localparam logic [2:0] TYPE_J   = 3'd5;
  localparam logic [2:0] TYPE_ILL = 3'd7;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN-1:0]     imm;
    logic [2:0]          instr_type;
    logic                alu_reg_reg_op;
    logic                alu_reg_con_op;
    logic                alu_branch_op;
    logic                load_op;
    logic                store_op;
    logic                jump_op;
    logic                illegal;
  } bundle_t;

  logic [6:0]  op;
  logic        sgn;
  logic [31:0] imm32;
  bundle_t     dec;
  bundle_t     out_q, out_d;
  logic        out_valid_q, out_valid_d;

  assign op  = in_instr[6:0];
  assign sgn = in_instr[31];

  // Decode the incoming word into a bundle; unused fields stay zero
  always_comb begin
    dec            = '0;
    imm32          = '0;
    dec.pc         = in_pc;
    dec.opcode     = op;
    dec.instr_type = TYPE_ILL;
    dec.illegal    = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      case (op)
        OP_OP, OP_AMO: begin
          dec.instr_type     = TYPE_R;
          dec.rd             = in_instr[11:7];
          dec.rs1            = in_instr[19:15];
          dec.rs2            = in_instr[24:20];
          dec.funct3         = in_instr[14:12];
          dec.funct7         = in_instr[31:25];
          dec.alu_reg_reg_op = (op == OP_OP);
          dec.illegal        = 1'b0;
        end
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
          dec.instr_type     = TYPE_I;
          dec.rd             = in_instr[11:7];
          dec.rs1            = in_instr[19:15];
          dec.funct3         = in_instr[14:12];
          imm32              = {{20{sgn}}, in_instr[31:20]};
          dec.alu_reg_con_op = (op == OP_IMM);
          dec.load_op        = (op == OP_LOAD);
          dec.jump_op        = (op == OP_JALR);
          dec.illegal        = 1'b0;
        end
        OP_STORE: begin
          dec.instr_type = TYPE_S;
          dec.rs1        = in_instr[19:15];
          dec.rs2        = in_instr[24:20];
          dec.funct3     = in_instr[14:12];
          imm32          = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
          dec.store_op   = 1'b1;
          dec.illegal    = 1'b0;
        end
        OP_BRANCH: begin
          dec.instr_type    = TYPE_B;
          dec.rs1           = in_instr[19:15];
          dec.rs2           = in_instr[24:20];
          dec.funct3        = in_instr[14:12];
          imm32             = {{20{sgn}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
          dec.alu_branch_op = 1'b1;
          dec.illegal       = 1'b0;
        end
        OP_AUIPC, OP_LUI: begin
          dec.instr_type = TYPE_U;
          dec.rd         = in_instr[11:7];
          imm32          = {in_instr[31:12], 12'b0};
          dec.illegal    = 1'b0;
        end
        OP_JAL: begin
          dec.instr_type = TYPE_J;
          dec.rd         = in_instr[11:7];
          imm32          = {{12{sgn}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
          dec.jump_op    = 1'b1;
          dec.illegal    = 1'b0;
        end
        default: ;
      endcase
    end
    dec.imm = XLEN'($signed(imm32));
  end

`ifdef ID_STAGE_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  // Next state: drain skid first, otherwise load output or park in skid
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid_q || out_ready) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Skid entry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Next state: load on input transfer, clear on consume or flush
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign opcode         = out_q.opcode;
  assign rd             = out_q.rd;
  assign rs1            = out_q.rs1;
  assign rs2            = out_q.rs2;
  assign funct3         = out_q.funct3;
  assign funct7         = out_q.funct7;
  assign imm            = out_q.imm;
  assign instr_type     = out_q.instr_type;
  assign alu_reg_reg_op = out_q.alu_reg_reg_op;
  assign alu_reg_con_op = out_q.alu_reg_con_op;
  assign alu_branch_op  = out_q.alu_branch_op;
  assign load_op        = out_q.load_op;
  assign store_op       = out_q.store_op;
  assign jump_op        = out_q.jump_op;
  assign illegal        = out_q.illegal;

endmodule
